// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Drives a combinational 8-bit ALU as a sequenced datapath. It accepts one
//   instruction at a time, presents operands and a one-hot function select,
//   samples the ALU result, writes it back into a 4-entry register file and
//   reports the write on the res_* port.
//
// Parameters
//   REG_COUNT  number of 8-bit registers (fixed at 4: indices are 2 bits)
//   EXEC_WAIT  cycles the ALU inputs are held before the result is sampled (>=1)
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   instr_valid/ready instruction handshake
//   opcode, rd, rs1, rs2, imm   instruction fields
//   alu_op1/op2/select          ALU drive; alu_result is its return path
//   res_valid/rd/data           one-cycle write-back report
//   busy                        high whenever the sequencer is not idle
//   flag_z, flag_n              zero / negative of the last write-back value
//                               (present only with ALU_SEQ_FLAGS_EN defined)
//
// Build option
//   ALU_SEQ_FLAGS_EN  adds flag_z / flag_n outputs and their registers.
//
// States
//   state  | meaning
//   IDLE   | ready for an instruction; operands captured on accept
//   EXEC   | ALU inputs held for EXEC_WAIT cycles, result sampled on the last
//   WB     | register write; res_valid pulses on the following cycle
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int REG_COUNT = 4,
  parameter int EXEC_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] opcode,
  input  logic [1:0] rd,
  input  logic [1:0] rs1,
  input  logic [1:0] rs2,
  input  logic [7:0] imm,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  output logic [7:0] alu_select,
  input  logic [7:0] alu_result,
  output logic       res_valid,
  output logic [1:0] res_rd,
  output logic [7:0] res_data,
  output logic       busy
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic       flag_z,
  output logic       flag_n
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_INC = 3'd2,
    OP_DEC = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_NOT = 3'd6,
    OP_LDI = 3'd7
  } opcode_e;

  localparam int CNT_W = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_WAIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       rd_q, rd_d;
  logic [7:0]       val_q, val_d;   // value to be written in WB
  logic [7:0]       op1_q, op1_d;
  logic [7:0]       op2_q, op2_d;
  logic [7:0]       regs_q [REG_COUNT];
  logic [7:0]       regs_d [REG_COUNT];
  logic             res_valid_q, res_valid_d;
  logic [1:0]       res_rd_q, res_rd_d;
  logic [7:0]       res_data_q, res_data_d;
  logic             wb_en;

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    val_d   = val_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    wb_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d  = opcode;
          rd_d  = rd;
          cnt_d = '0;
          if (opcode == OP_LDI) begin
            // LDI bypasses the ALU entirely; its inputs are parked at zero.
            val_d   = imm;
            op1_d   = 8'h00;
            op2_d   = 8'h00;
            state_d = S_WB;
          end else begin
            op1_d   = regs_q[rs1];
            op2_d   = regs_q[rs2];
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == CNT_LAST) begin
          val_d   = alu_result;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        wb_en   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register file write and write-back report
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = regs_q[i];
    end
    res_valid_d = wb_en;
    res_rd_d    = res_rd_q;
    res_data_d  = res_data_q;
    if (wb_en) begin
      regs_d[rd_q] = val_q;
      res_rd_d     = rd_q;
      res_data_d   = val_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= 3'd0;
      rd_q        <= 2'd0;
      val_q       <= 8'h00;
      op1_q       <= 8'h00;
      op2_q       <= 8'h00;
      res_valid_q <= 1'b0;
      res_rd_q    <= 2'd0;
      res_data_q  <= 8'h00;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      val_q       <= val_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      res_valid_q <= res_valid_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Select is only live while the ALU is being exercised, so it is zero in
  // IDLE, in WB and for LDI without needing its own register.
  always_comb begin
    alu_select = 8'h00;
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_ADD:  alu_select = 8'h02;
        OP_SUB:  alu_select = 8'h04;
        OP_INC:  alu_select = 8'h08;
        OP_DEC:  alu_select = 8'h10;
        OP_AND:  alu_select = 8'h20;
        OP_OR:   alu_select = 8'h40;
        OP_NOT:  alu_select = 8'h80;
        default: alu_select = 8'h00;
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  assign res_valid   = res_valid_q;
  assign res_rd      = res_rd_q;
  assign res_data    = res_data_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic flag_z_q, flag_z_d;
  logic flag_n_q, flag_n_d;

  always_comb begin
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    if (wb_en) begin
      flag_z_d = (val_q == 8'h00);
      flag_n_d = val_q[7];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`endif

endmodule
